// File: rtl/axis_lane_packer.sv
// AXI-Stream lane packer: compacts sparse/partial 4-bit-lane beats into full output beats, keeping tlast.
// Define AXIS_PACK_SPARSE_KEEP_EN to accept arbitrary tkeep masks (otherwise masks must be LSB-contiguous).
module axis_lane_packer #(
   parameter int DATA_WIDTH = 16,
   parameter int LANE_WIDTH = 4,
   localparam int LANES     = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [LANES-1:0]      s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [LANES-1:0]      m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int CW    = $clog2(2 * LANES);
   localparam int RCW   = $clog2(LANES);
   localparam int RES_W = (LANES - 1) * LANE_WIDTH;

   typedef enum logic {ST_ACCEPT, ST_FLUSH} state_t;

   state_t                  r_state,   w_state_nx;
   logic [RCW-1:0]          r_res_cnt, w_res_cnt_nx;
   logic [RES_W-1:0]        r_res,     w_res_nx;
   logic [DATA_WIDTH-1:0]   r_tdata,   w_tdata_nx;
   logic [LANES-1:0]        r_tkeep,   w_tkeep_nx;
   logic                    r_tlast,   w_tlast_nx;
   logic                    r_tvalid,  w_tvalid_nx;

   logic                    w_slot_free;
   logic                    w_accept;
   logic [DATA_WIDTH-1:0]   w_new;
   logic [CW-1:0]           w_in_cnt;
   logic [CW-1:0]           w_n;
   logic [CW-1:0]           w_rem;
   logic [DATA_WIDTH+RES_W-1:0] w_comb;
   logic [LANES-1:0]        w_part_keep;
   logic [LANES-1:0]        w_flush_keep;

`ifdef AXIS_PACK_SPARSE_KEEP_EN
   // Running count of set keep bits below lane i is the destination slot of lane i.
   always_comb begin
      w_new    = '0;
      w_in_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         if (s_axis_tkeep[i]) begin
            w_new[w_in_cnt*LANE_WIDTH +: LANE_WIDTH] = s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH];
            w_in_cnt = w_in_cnt + CW'(1);
         end
      end
   end
`else
   always_comb begin
      w_in_cnt = '0;
      w_new    = '0;
      for (int i = 0; i < LANES; i++)
         w_in_cnt = w_in_cnt + CW'(s_axis_tkeep[i]);
      for (int i = 0; i < LANES; i++)
         if (CW'(i) < w_in_cnt)
            w_new[i*LANE_WIDTH +: LANE_WIDTH] = s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH];
   end
`endif

   assign w_slot_free   = !r_tvalid || m_axis_tready;
   assign s_axis_tready = (r_state == ST_ACCEPT) && w_slot_free && aresetn;
   assign w_accept      = s_axis_tvalid && s_axis_tready;

   // Residual lanes above r_res_cnt are kept zero, so an OR merges old and new lanes.
   assign w_n    = CW'(r_res_cnt) + w_in_cnt;
   assign w_rem  = w_n - CW'(LANES);
   assign w_comb = ({{RES_W{1'b0}}, w_new} << (r_res_cnt * LANE_WIDTH))
                 | {{DATA_WIDTH{1'b0}}, r_res};

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_part_keep[j]  = CW'(j) < w_n;
         w_flush_keep[j] = RCW'(j) < r_res_cnt;
      end
   end

   // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nx   = r_state;
      w_res_cnt_nx = r_res_cnt;
      w_res_nx     = r_res;
      w_tdata_nx   = r_tdata;
      w_tkeep_nx   = r_tkeep;
      w_tlast_nx   = r_tlast;
      w_tvalid_nx  = r_tvalid && !m_axis_tready;

      case (r_state)
         ST_ACCEPT: begin
            if (w_accept) begin
               if (w_n >= CW'(LANES)) begin
                  w_tdata_nx   = w_comb[DATA_WIDTH-1:0];
                  w_tkeep_nx   = '1;
                  w_tvalid_nx  = 1'b1;
                  w_res_nx     = w_comb[DATA_WIDTH +: RES_W];
                  w_res_cnt_nx = RCW'(w_rem);
                  w_tlast_nx   = s_axis_tlast && (w_rem == '0);
                  if (s_axis_tlast && (w_rem != '0))
                     w_state_nx = ST_FLUSH;
               end else if (s_axis_tlast) begin
                  w_tdata_nx   = w_comb[DATA_WIDTH-1:0];
                  w_tkeep_nx   = w_part_keep;
                  w_tlast_nx   = 1'b1;
                  w_tvalid_nx  = 1'b1;
                  w_res_nx     = '0;
                  w_res_cnt_nx = '0;
               end else begin
                  w_res_nx     = w_comb[RES_W-1:0];
                  w_res_cnt_nx = RCW'(w_n);
               end
            end
         end
         ST_FLUSH: begin
            if (w_slot_free) begin
               w_tdata_nx   = {{LANE_WIDTH{1'b0}}, r_res};
               w_tkeep_nx   = w_flush_keep;
               w_tlast_nx   = 1'b1;
               w_tvalid_nx  = 1'b1;
               w_res_nx     = '0;
               w_res_cnt_nx = '0;
               w_state_nx   = ST_ACCEPT;
            end
         end
         default: w_state_nx = ST_ACCEPT;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= ST_ACCEPT;
         r_res_cnt <= '0;
         r_res     <= '0;
         r_tdata   <= '0;
         r_tkeep   <= '0;
         r_tlast   <= 1'b0;
         r_tvalid  <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_res_cnt <= w_res_cnt_nx;
         r_res     <= w_res_nx;
         r_tdata   <= w_tdata_nx;
         r_tkeep   <= w_tkeep_nx;
         r_tlast   <= w_tlast_nx;
         r_tvalid  <= w_tvalid_nx;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_lane_packer.sv
// Scoreboard bench for axis_lane_packer (DATA_WIDTH=16); follows AXIS_PACK_SPARSE_KEEP_EN like the RTL.
module tb_axis_lane_packer;

   localparam int DW = 16;
   localparam int NL = 4;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [NL-1:0] k;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [NL-1:0] s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [NL-1:0] m_tkeep;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;

   int n_checks = 0;
   int n_pass   = 0;
   bit rnd_bp   = 1'b0;

   beat_t      exp_q[$];
   logic [3:0] lane_q[$];
   beat_t      mon_e;

   axis_lane_packer #(.DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: a FIFO of lanes; four lanes make a full beat, tlast flushes the rest.
   task automatic model_beat(input logic [DW-1:0] d, input logic [NL-1:0] k, input logic l);
      beat_t b;
      bit    full_sent = 1'b0;
`ifdef AXIS_PACK_SPARSE_KEEP_EN
      for (int i = 0; i < NL; i++)
         if (k[i]) lane_q.push_back(d[i*4 +: 4]);
`else
      for (int i = 0; i < $countones(k); i++)
         lane_q.push_back(d[i*4 +: 4]);
`endif
      if (lane_q.size() >= NL) begin
         b.d = '0;
         for (int j = 0; j < NL; j++) b.d[j*4 +: 4] = lane_q.pop_front();
         b.k = '1;
         b.l = l && (lane_q.size() == 0);
         exp_q.push_back(b);
         full_sent = 1'b1;
      end
      if (l && (lane_q.size() > 0 || !full_sent)) begin
         b.d = '0;
         b.k = '0;
         for (int j = 0; lane_q.size() > 0; j++) begin
            b.d[j*4 +: 4] = lane_q.pop_front();
            b.k[j] = 1'b1;
         end
         b.l = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   // Returns #1 after the accepting clock edge.
   task automatic send(input logic [DW-1:0] d, input logic [NL-1:0] k, input logic l);
      int t = 0;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!s_tready) begin
         check("send_timeout", 32'(s_tready), 32'd1);
         s_tvalid = 1'b0;
         return;
      end
      model_beat(d, k, l);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (aresetn && m_tvalid && m_tready) begin
         check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("out_tdata", 32'(m_tdata), 32'(mon_e.d));
            check("out_tkeep", 32'(m_tkeep), 32'(mon_e.k));
            check("out_tlast", 32'(m_tlast), 32'(mon_e.l));
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_bp) begin
         #1;
         m_tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [NL-1:0] k;

      // Reset values
      #3;
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tdata",  32'(m_tdata),  32'd0);
      check("rst_tkeep",  32'(m_tkeep),  32'd0);
      check("rst_tlast",  32'(m_tlast),  32'd0);
      check("rst_sready", 32'(s_tready), 32'd0);
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      check("rel_sready", 32'(s_tready), 32'd1);
      idle(1);

      // Two half beats -> one full beat one cycle after the second accept
      send(16'h00BA, 4'b0011, 1'b0);
      check("half_no_out", 32'(m_tvalid), 32'd0);
      send(16'h00DC, 4'b0011, 1'b1);
      check("half_latency", 32'(m_tvalid), 32'd1);
      drain("drain_half");

      // Overflow on tlast: one FLUSH bubble on the input side
      send(16'h0CBA, 4'b0111, 1'b0);
      send(16'h0FED, 4'b0111, 1'b1);
      check("flush_sready_lo", 32'(s_tready), 32'd0);
      idle(1);
      check("flush_sready_hi", 32'(s_tready), 32'd1);
      drain("drain_overflow");

      // Backpressure: output held stable for 5 cycles
      m_tready = 1'b0;
      send(16'h1234, 4'b1111, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_tvalid", 32'(m_tvalid), 32'd1);
         check("bp_tdata",  32'(m_tdata),  32'h1234);
         check("bp_tkeep",  32'(m_tkeep),  32'hF);
         check("bp_tlast",  32'(m_tlast),  32'd1);
         check("bp_sready", 32'(s_tready), 32'd0);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      idle(1);
      check("bp_transfer", 32'(m_tvalid), 32'd0);
      drain("drain_bp");

      // Sparse mask
      send(16'hA0B0, 4'b1010, 1'b0);
      send(16'h00DC, 4'b0011, 1'b1);
      drain("drain_sparse");

      // Empty tlast beat
      send(16'h5555, 4'b0000, 1'b1);
      drain("drain_empty");

      // Reset while stuck in FLUSH behind backpressure
      m_tready = 1'b0;
      send(16'h0CBA, 4'b0111, 1'b0);
      send(16'h0FED, 4'b0111, 1'b1);
      idle(1);
      check("pre_rst_sready", 32'(s_tready), 32'd0);
      #2;
      aresetn = 1'b0;
      #1;
      check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
      check("mid_rst_tdata",  32'(m_tdata),  32'd0);
      check("mid_rst_tkeep",  32'(m_tkeep),  32'd0);
      check("mid_rst_tlast",  32'(m_tlast),  32'd0);
      check("mid_rst_sready", 32'(s_tready), 32'd0);
      exp_q.delete();
      lane_q.delete();
      @(negedge clk);
      aresetn = 1'b1;
      m_tready = 1'b1;
      #1;
      check("post_rst_sready", 32'(s_tready), 32'd1);
      idle(1);
      send(16'h4321, 4'b1111, 1'b1);
      drain("drain_post_rst");

      // Random traffic with random output backpressure
      rnd_bp = 1'b1;
      for (int b = 0; b < 60; b++) begin
`ifdef AXIS_PACK_SPARSE_KEEP_EN
         k = 4'($urandom_range(0, 15));
`else
         k = 4'((5'd1 << $urandom_range(0, 4)) - 5'd1);
`endif
         send(16'($urandom), k, (b == 59) || ($urandom_range(0, 3) == 0));
      end
      rnd_bp = 1'b0;
      @(posedge clk);
      #2;
      m_tready = 1'b1;
      drain("drain_random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
